fwd_hazard_ctrl: RTL and testbench

- Pipeline forwarding and hazard controller for the 16-bit MIPS datapath.
- Tracks the destination register of instructions in the EX, DM and WB stages.
- Drives the register bank's operand-source selects (mux_sel_A/mux_sel_B) and its RW_dm/write-enable signals.
- Raises a one-cycle stall on load-use hazards and inserts a bubble into EX.

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/fwd_hazard_ctrl_if.sv | 40 ++++
 rtl/fwd_select.sv | 23 ++
 rtl/fwd_hazard_ctrl.sv | 82 ++++++++
 tb/tb_fwd_hazard_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: select encodings,
// the pipeline stage entry and the register-hit helper.
package fwd_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_EX = 2'b01,
    SEL_DM = 2'b10,
    SEL_WB = 2'b11
  } sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  we;
    logic                  load;
  } stage_t;

  // R0 is hardwired, so it never matches a producer.
  function automatic logic entry_hits(stage_t e, logic [REG_AW_DEF-1:0] r);
    return e.valid & e.we & (e.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and register-bank control bundle of the hazard controller.
interface fwd_hazard_ctrl_if
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              id_valid;
  logic [REG_AW-1:0] RA;
  logic [REG_AW-1:0] RB;
  logic              ra_used;
  logic              rb_used;
  logic              imm_sel;
  logic [REG_AW-1:0] RW_id;
  logic              wr_en_id;
  logic              is_load_id;
  logic              flush;

  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              stall;
  logic [REG_AW-1:0] RW_dm;
  logic [REG_AW-1:0] RW_wb;
  logic              wb_we;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, RA, RB, ra_used, rb_used, imm_sel,
           RW_id, wr_en_id, is_load_id, flush,
    input  mux_sel_A, mux_sel_B, stall, RW_dm, RW_wb, wb_we, stall_cnt
  );

  modport slave (
    input  id_valid, RA, RB, ra_used, rb_used, imm_sel,
           RW_id, wr_en_id, is_load_id, flush,
    output mux_sel_A, mux_sel_B, stall, RW_dm, RW_wb, wb_we, stall_cnt
  );

endinterface

// File: rtl/fwd_select.sv
// Priority compare of one source register against the EX/DM/WB entries;
// the youngest matching producer wins.
module fwd_select
  import fwd_pkg::*;
(
  input  logic [REG_AW_DEF-1:0] src,
  input  logic                  used,
  input  stage_t                ex,
  input  stage_t                dm,
  input  stage_t                wb,
  output sel_e                  sel
);

  always_comb begin
    sel = SEL_RF;
    if (used) begin
      if (entry_hits(ex, src))      sel = SEL_EX;
      else if (entry_hits(dm, src)) sel = SEL_DM;
      else if (entry_hits(wb, src)) sel = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 16-bit MIPS pipeline:
// tracks EX/DM/WB destinations, drives operand selects, stalls and write-back.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  fwd_hazard_ctrl_if.slave  bus
);

  stage_t           ex_q, dm_q, wb_q;
  stage_t           ex_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall_c;
  logic             a_used_c, b_used_c;
  logic             a_ex_load_c, b_ex_load_c;
  sel_e             sel_a_c, sel_b_c;

  assign a_used_c = bus.id_valid & bus.ra_used;
  assign b_used_c = bus.id_valid & bus.rb_used & ~bus.imm_sel;

  fwd_select u_sel_a (
    .src  (REG_AW_DEF'(bus.RA)),
    .used (a_used_c),
    .ex   (ex_q),
    .dm   (dm_q),
    .wb   (wb_q),
    .sel  (sel_a_c)
  );

  fwd_select u_sel_b (
    .src  (REG_AW_DEF'(bus.RB)),
    .used (b_used_c),
    .ex   (ex_q),
    .dm   (dm_q),
    .wb   (wb_q),
    .sel  (sel_b_c)
  );

  // Load result is only available from DM, so a consumer directly behind it waits one cycle.
  assign a_ex_load_c = a_used_c & entry_hits(ex_q, REG_AW_DEF'(bus.RA));
  assign b_ex_load_c = b_used_c & entry_hits(ex_q, REG_AW_DEF'(bus.RB));
  assign stall_c     = ~bus.flush & ex_q.load & (a_ex_load_c | b_ex_load_c);

  // Next EX entry: accepted ID instruction or a bubble.
  always_comb begin
    ex_d = '0;
    if (bus.id_valid && !stall_c && !bus.flush) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = REG_AW_DEF'(bus.RW_id);
      ex_d.we    = bus.wr_en_id;
      ex_d.load  = bus.is_load_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      dm_q        <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q <= dm_q;
      dm_q <= ex_q;
      ex_q <= ex_d;
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.mux_sel_A = sel_a_c;
  assign bus.mux_sel_B = sel_b_c;
  assign bus.stall     = stall_c;
  assign bus.RW_dm     = REG_AW'(dm_q.rd);
  assign bus.RW_wb     = REG_AW'(wb_q.rd);
  assign bus.wb_we     = wb_q.valid & wb_q.we & (wb_q.rd != '0);
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic rau, input logic rbu, input logic imm,
                        input logic [4:0] rw, input logic we, input logic ld,
                        input logic fl);
    bus.id_valid   = v;
    bus.RA         = ra;
    bus.RB         = rb;
    bus.ra_used    = rau;
    bus.rb_used    = rbu;
    bus.imm_sel    = imm;
    bus.RW_id      = rw;
    bus.wr_en_id   = we;
    bus.is_load_id = ld;
    bus.flush      = fl;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  int nst;

  initial begin
    // Reset with a live instruction at ID
    rst_n = 1'b0;
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_sel_a", 32'(bus.mux_sel_A), 32'd0);
    check("rst_sel_b", 32'(bus.mux_sel_B), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rw_dm", 32'(bus.RW_dm), 32'd0);
    check("rst_rw_wb", 32'(bus.RW_wb), 32'd0);
    check("rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    rst_n = 1'b1;
    nop();
    tick();
    check("rel_rw_dm", 32'(bus.RW_dm), 32'd0);
    check("rel_wb_we", 32'(bus.wb_we), 32'd0);

    // ALU chain: add r7, then writers of r3 and r4 that read r7/r3
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("alu_first_a", 32'(bus.mux_sel_A), 32'd0);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    check("b2b_ex_a", 32'(bus.mux_sel_A), 32'd1);
    tick();
    set_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    check("one_between_dm_a", 32'(bus.mux_sel_A), 32'd2);
    check("b2b_ex_b", 32'(bus.mux_sel_B), 32'd1);
    check("pass_rw_dm_t2", 32'(bus.RW_dm), 32'd7);
    tick();
    set_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("two_between_wb_a", 32'(bus.mux_sel_A), 32'd3);
    check("one_between_dm_b", 32'(bus.mux_sel_B), 32'd2);
    check("pass_rw_wb_t3", 32'(bus.RW_wb), 32'd7);
    check("pass_wb_we_t3", 32'(bus.wb_we), 32'd1);
    drain();

    // Priority: r5 in WB, DM and EX
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("prio_a", 32'(bus.mux_sel_A), 32'd1);
    check("prio_b", 32'(bus.mux_sel_B), 32'd1);
    set_id(1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("unused_a", 32'(bus.mux_sel_A), 32'd0);
    check("imm_b", 32'(bus.mux_sel_B), 32'd0);
    drain();

    // R0 writer never forwarded, never written back
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("r0_a", 32'(bus.mux_sel_A), 32'd0);
    check("r0_b", 32'(bus.mux_sel_B), 32'd0);
    nop();
    tick();
    tick();
    check("r0_wb_we", 32'(bus.wb_we), 32'd0);
    drain();

    // Load-use on RB
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    check("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    check("lu_resolved", 32'(bus.stall), 32'd0);
    check("lu_sel_b_dm", 32'(bus.mux_sel_B), 32'd2);
    tick();
    nop();
    check("lu_bubble_dm", 32'(bus.RW_dm), 32'd0);
    check("lu_load_wb", 32'(bus.RW_wb), 32'd6);
    check("lu_load_wb_we", 32'(bus.wb_we), 32'd1);
    tick();
    check("lu_cons_dm", 32'(bus.RW_dm), 32'd8);
    drain();

    // Load-use masked by immediate
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    check("imm_no_stall", 32'(bus.stall), 32'd0);
    check("imm_sel_b", 32'(bus.mux_sel_B), 32'd0);
    drain();

    // Flush overrides stall
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    check("flush_no_stall", 32'(bus.stall), 32'd0);
    tick();
    nop();
    tick();
    check("flush_load_wb_we", 32'(bus.wb_we), 32'd1);
    tick();
    check("flush_slot_wb_we", 32'(bus.wb_we), 32'd0);
    check("flush_slot_rw_wb", 32'(bus.RW_wb), 32'd0);
    check("flush_cnt", 32'(bus.stall_cnt), 32'd1);
    drain();

    // Saturation: a self-dependent load held at ID stalls every other cycle
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    nst = 0;
    for (int i = 0; i < 80 && nst < 20; i++) begin
      if (bus.stall) nst++;
      tick();
    end
    check("sat_stalls_seen", 32'(nst), 32'd20);
    check("sat_cnt", 32'(bus.stall_cnt), 32'd15);

    // Reset mid-operation discards in-flight loads
    rst_n = 1'b0;
    tick();
    check("mid_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    check("mid_rst_rw_dm", 32'(bus.RW_dm), 32'd0);
    rst_n = 1'b1;
    nop();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_wb_we", 32'(bus.wb_we), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
